// File: rtl/pc_pkg.sv
// Shared constants, command encoding and address helper for the RAT program counter.
package pc_pkg;

    localparam int ADDR_W      = 10;
    localparam int STACK_DEPTH = 8;
    localparam int STK_CNT_W   = $clog2(STACK_DEPTH + 1);

    localparam logic [ADDR_W-1:0] RESET_VEC = 10'h000;
    localparam logic [ADDR_W-1:0] INTR_VEC  = 10'h3FF;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'b000,
        CMD_INC  = 3'b001,
        CMD_JUMP = 3'b010,
        CMD_CALL = 3'b011,
        CMD_RET  = 3'b100,
        CMD_INTR = 3'b101,
        CMD_RETI = 3'b110,
        CMD_RSVD = 3'b111
    } pc_cmd_t;

    // Increment wraps naturally at the address width.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO: pointer-indexed register array with occupancy count.
module ret_stack #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 10,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign wr_ptr_s  = PTR_W'(count_q);
    assign rd_ptr_s  = PTR_W'(count_q - CNT_W'(1));
    assign data_o    = mem_q[rd_ptr_s];
    assign count_o   = count_q;

    // Occupancy next-state; push and pop never coincide.
    always_comb begin
        count_d = count_q;
        if (do_push_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents carry no reset value.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_s] <= data_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and next-address selection for the RAT core, including
// call/return/interrupt handling over the internal return stack.
module pc_fetch_unit
    import pc_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [2:0]           CMD,
    input  logic [ADDR_W-1:0]    FROM_IMMED,
    input  logic                 CLR_ERR,
    output logic [ADDR_W-1:0]    PC_COUNT,
    output logic [STK_CNT_W-1:0] STK_CNT,
    output logic                 INT_ACTIVE,
    output logic                 OVF,
    output logic                 UNF
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              int_q, int_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] push_data_s;
    logic [ADDR_W-1:0] pop_data_s;
    logic              full_s;
    logic              empty_s;
    logic [ADDR_W-1:0] pc_inc_s;
    pc_cmd_t           cmd_s;

    assign cmd_s    = pc_cmd_t'(CMD);
    assign pc_inc_s = pc_incr(pc_q);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (push_data_s),
        .data_o  (pop_data_s),
        .count_o (STK_CNT),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Command decode: next PC, stack requests, interrupt state and error flags.
    always_comb begin
        pc_d        = pc_q;
        int_d       = int_q;
        ovf_d       = CLR_ERR ? 1'b0 : ovf_q;
        unf_d       = CLR_ERR ? 1'b0 : unf_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_data_s = pc_inc_s;
        case (cmd_s)
            CMD_INC: begin
                pc_d = pc_inc_s;
            end
            CMD_JUMP: begin
                pc_d = FROM_IMMED;
            end
            CMD_CALL: begin
                pc_d = FROM_IMMED;
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            CMD_RET: begin
                if (empty_s) begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc_s;
                end else begin
                    pop_s = 1'b1;
                    pc_d  = pop_data_s;
                end
            end
            CMD_INTR: begin
                // No nesting: a second interrupt while servicing is dropped.
                if (int_q) begin
                    pc_d = pc_q;
                end else begin
                    pc_d        = INTR_VEC;
                    int_d       = 1'b1;
                    push_data_s = pc_q;
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
            end
            CMD_RETI: begin
                int_d = 1'b0;
                if (empty_s) begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc_s;
                end else begin
                    pop_s = 1'b1;
                    pc_d  = pop_data_s;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // PC, interrupt and sticky error registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_VEC;
            int_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            int_q <= int_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign PC_COUNT   = pc_q;
    assign INT_ACTIVE = int_q;
    assign OVF        = ovf_q;
    assign UNF        = unf_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and next-address logic for the RAT core.
- Drives the 10-bit instruction address into the synchronous program ROM.
- Holds the PC, computes the next address (increment, jump, call, return, interrupt) and owns an internal hardware return-address stack (LIFO).
- Commands come from the control unit one cycle per instruction; the ROM returns the instruction one cycle after PC_COUNT changes.

Parameters:
ADDR_W, 10, PC and address width (1024-word program space)
STACK_DEPTH, 8, return-stack entries
RESET_VEC, 10'h000, PC value after reset
INTR_VEC, 10'h3FF, interrupt service entry address

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  reset, asynchronous, active-low
CMD  input  3  PC command for this cycle (encoding in package)
FROM_IMMED  input  ADDR_W  jump/call target from instruction field
CLR_ERR  input  1  synchronous clear of OVF/UNF
PC_COUNT  output  ADDR_W  registered PC; drives program ROM address
STK_CNT  output  $clog2(STACK_DEPTH+1)  current stack occupancy
INT_ACTIVE  output  1  high while servicing an interrupt
OVF  output  1  sticky stack-overflow flag
UNF  output  1  sticky stack-underflow flag

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (RST_N).
- Reset value of every output:
  - PC_COUNT = RESET_VEC
  - STK_CNT = 0
  - INT_ACTIVE = 0
  - OVF = 0
  - UNF = 0
  - Stack contents are don't-care.
- All state updates on the rising CLK edge; CMD is sampled once per edge. PC_COUNT changes one cycle after CMD is applied.
- Commands:
  - NOP (000): hold all state.
  - INC (001): PC <= PC+1, modulo 2^ADDR_W (3FF -> 000).
  - JUMP (010): PC <= FROM_IMMED.
  - CALL (011): push PC+1 (wrapped), PC <= FROM_IMMED.
  - RET (100): pop, PC <= popped value.
  - INTR (101): push PC_COUNT (the not-yet-executed address), PC <= INTR_VEC, INT_ACTIVE <= 1.
  - RETI (110): pop, PC <= popped value, INT_ACTIVE <= 0.
  - 111: reserved, behaves as NOP.
- Stack full (STK_CNT == STACK_DEPTH) on CALL/INTR:
  - Push suppressed; OVF <= 1.
  - Jump/vector still taken; INT_ACTIVE still set for INTR.
  - STK_CNT unchanged.
- Stack empty on RET:
  - UNF <= 1, PC <= PC+1, STK_CNT stays 0.
- Stack empty on RETI:
  - UNF <= 1, PC <= PC+1, INT_ACTIVE <= 0.
- INTR while INT_ACTIVE=1: ignored, treated as NOP (no nesting).
- OVF/UNF are sticky until RST_N low or CLR_ERR=1.
  - If CLR_ERR and a new error occur in the same cycle, the new error wins (flag = 1).
- Stack is a pointer-indexed register array. Push writes at STK_CNT and increments it; pop reads entry STK_CNT-1 and decrements it. No read-during-write hazard exists because push and pop are mutually exclusive per CMD.
- Reset asserted mid-operation: state returns to reset values immediately, independent of CLK. Deassertion is synchronised externally.

Decomposition:
- Package pc_pkg:
  - pc_cmd_t enum (3 bits, values above)
  - ADDR_W
  - RESET_VEC
  - INTR_VEC
- Sub-module ret_stack:
  - Parameterised LIFO (DEPTH, WIDTH) with push, pop, data_in, data_out, count, full, empty.
  - Async active-low reset on pointer/count.
- pc_fetch_unit holds the PC register, command decode, error flags and INT_ACTIVE.

Test Plan:
- Reset and increment wrap:
  - RST_N low mid-run -> PC_COUNT=000, STK_CNT=0 immediately.
  - Release, JUMP 3FE, INC, INC -> PC_COUNT 3FE, 3FF, 000.
- Nested call and return:
  - PC=010, CALL 100 -> PC=100, STK_CNT=1.
  - CALL 200 from 100 -> STK_CNT=2.
  - RET -> PC=101; RET -> PC=011; STK_CNT=0, OVF=UNF=0.
- Overflow:
  - 9 consecutive CALLs to 050 from PC=050 -> STK_CNT saturates at 8, OVF=1 after the 9th, PC=050.
  - CLR_ERR -> OVF=0.
- Underflow:
  - Empty stack, PC=020, RET -> PC=021, UNF=1, STK_CNT=0.
  - Same cycle CLR_ERR=1 with RET -> UNF=1.
- Interrupt:
  - PC=0A5, INTR -> PC=3FF, INT_ACTIVE=1, STK_CNT=1.
  - Second INTR -> no change.
  - RETI -> PC=0A5, INT_ACTIVE=0, STK_CNT=0.
- Reserved and NOP:
  - CMD=111 and CMD=000 for 5 cycles each -> PC_COUNT, STK_CNT and flags unchanged.
